// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared state encoding and width helpers for seq_adder
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single-step adder still needs a one-bit counter.
  function automatic int cnt_width(input int steps);
    return (clog2(steps) < 1) ? 1 : clog2(steps);
  endfunction

endpackage

// File: rtl/seq_adder_add_slice.sv
// rtl/seq_adder_add_slice.sv - DIGIT-bit ripple adder built from half-adder pairs
module add_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic h1_s;
    logic h1_c;
    logic h2_c;
    // First half adder on the operands, second folds in the carry.
    assign h1_s     = x[i] ^ y[i];
    assign h1_c     = x[i] & y[i];
    assign s[i]     = h1_s ^ c[i];
    assign h2_c     = h1_s & c[i];
    assign c[i+1]   = h1_c | h2_c;
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/seq_adder.sv
// rtl/seq_adder.sv - multi-cycle add/subtract, DIGIT bits per clock with registered carry
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("seq_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;

  add_slice #(.DIGIT(DIGIT)) u_slice (
    .x  (op_a[DIGIT-1:0]),
    .y  (op_b[DIGIT-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Each new slice enters at the top, so after STEPS shifts slice 0 sits at the bottom.
  assign acc_next = (acc >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1] ^ sub;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          carry <= slice_co;
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            count <= '0;
            sum   <= acc_next;
            cout  <= slice_co;
            ovf   <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_adder.sv
// tb/tb_seq_adder.sv - directed vector bench for seq_adder (DIGIT=2 and DIGIT=8 instances)
module tb_seq_adder;

  logic       clk;
  logic       rst_n;
  logic       start0;
  logic       start1;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy0, done0, cout0, ovf0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum0, sum1;

  int vecs;
  int miscompares;
  int d0_first, d0_cnt, d1_first, d1_cnt;
  logic b0_k1, b0_k6;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];

  seq_adder #(.WIDTH(8), .DIGIT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  seq_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Start both instances on the same edge and record done timing over 8 sample cycles.
  task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    sub = s; a = x; b = y; cin = c;
    start0 = 1'b1; start1 = 1'b1;
    d0_first = 0; d0_cnt = 0; d1_first = 0; d1_cnt = 0;
    b0_k1 = 1'b0; b0_k6 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (k == 1) b0_k1 = busy0;
      if (k == 6) b0_k6 = busy0;
      if (done0) begin d0_cnt++; if (d0_first == 0) d0_first = k; end
      if (done1) begin d1_cnt++; if (d1_first == 0) d1_first = k; end
    end
  endtask

  initial begin
    vecs = 0;
    miscompares = 0;
    rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;

    tbl[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

    #12 rst_n = 1'b0;
    #1;
    chk("reset busy0", busy0, 0);
    chk("reset done0", done0, 0);
    chk("reset sum0", sum0, 0);
    chk("reset cout0", cout0, 0);
    chk("reset ovf0", ovf0, 0);
    chk("reset busy1", busy1, 0);
    chk("reset sum1", sum1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin);
      chk($sformatf("v%0d sum0", i), sum0, tbl[i].sum);
      chk($sformatf("v%0d cout0", i), cout0, tbl[i].cout);
      chk($sformatf("v%0d ovf0", i), ovf0, tbl[i].ovf);
      chk($sformatf("v%0d sum1", i), sum1, tbl[i].sum);
      chk($sformatf("v%0d cout1", i), cout1, tbl[i].cout);
      chk($sformatf("v%0d ovf1", i), ovf1, tbl[i].ovf);
      chk($sformatf("v%0d done0 cycle", i), d0_first, 5);
      chk($sformatf("v%0d done0 pulses", i), d0_cnt, 1);
      chk($sformatf("v%0d done1 cycle", i), d1_first, 2);
      chk($sformatf("v%0d done1 pulses", i), d1_cnt, 1);
      chk($sformatf("v%0d busy0 k1", i), b0_k1, 1);
      chk($sformatf("v%0d busy0 k6", i), b0_k6, 0);
    end

    // Re-pulsed start and operand changes while dut0 is busy must be ignored.
    @(negedge clk);
    sub = 1'b0; a = 8'h7F; b = 8'h01; cin = 1'b0; start0 = 1'b1;
    d0_first = 0; d0_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done0) begin d0_cnt++; if (d0_first == 0) d0_first = k; end
      start0 = (k <= 5);
      a = 8'h00; b = 8'h00; sub = 1'b1;
    end
    start0 = 1'b0;
    chk("restart done pulses", d0_cnt, 1);
    chk("restart done cycle", d0_first, 5);
    chk("restart sum0", sum0, 8'h80);
    chk("restart ovf0", ovf0, 1);
    chk("restart cout0", cout0, 0);

    // Asynchronous reset during RUN aborts without a done pulse.
    @(negedge clk);
    sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy0", busy0, 0);
    chk("abort done0", done0, 0);
    chk("abort sum0", sum0, 0);
    chk("abort cout0", cout0, 0);
    chk("abort ovf0", ovf0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done0) d0_cnt++;
    end
    chk("abort no done", d0_cnt, 0);

    run_op(1'b0, 8'h10, 8'h20, 1'b0);
    chk("post-abort sum0", sum0, 8'h30);
    chk("post-abort sum1", sum1, 8'h30);
    chk("post-abort done0 cycle", d0_first, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
